// File: rtl/ram_sync_clr.sv
// ram_sync_clr: single-port byte-writable RAM with registered read data and an
// optional sequential zero-clear controller, built in when RAM_CLEAR_EN is defined.
module ram_sync_clr #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                rw,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   din,
    input  logic [DATA_W/8-1:0] be,
    input  logic                clr,
    output logic [DATA_W-1:0]   dout,
    output logic                rd_valid,
    output logic                busy
);
    localparam int unsigned DEPTH = 2**ADDR_W;
    localparam int unsigned NB    = DATA_W/8;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] wmask;
    logic [ADDR_W-1:0] clr_ptr;
    logic              clr_we;
    logic              acc_ok;

`ifdef RAM_CLEAR_EN
    typedef enum logic {IDLE, CLEAR} state_t;
    state_t state;

    // rst and clr both (re)start the sweep at word 0; rst wins simply by coming first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_ptr <= '0;
        end else if (clr) begin
            state   <= CLEAR;
            clr_ptr <= '0;
        end else if (state == CLEAR) begin
            if (clr_ptr == '1)
                state <= IDLE;
            else
                clr_ptr <= clr_ptr + 1'b1;
        end
    end

    assign busy   = (state == CLEAR);
    assign clr_we = !rst && (state == CLEAR);
    assign acc_ok = !rst && (state == IDLE) && !clr && en;
`else
    logic clr_unused;

    assign clr_unused = clr;
    assign clr_ptr    = '0;
    assign busy       = 1'b0;
    assign clr_we     = 1'b0;
    assign acc_ok     = !rst && en;
`endif

    for (genvar k = 0; k < NB; k++) begin : g_mask
        assign wmask[8*k +: 8] = {8{be[k]}};
    end

    // Byte-enable write expressed as a masked merge so one process owns the array.
    always_ff @(posedge clk) begin
        if (clr_we)
            mem[clr_ptr] <= '0;
        else if (acc_ok && rw)
            mem[addr] <= (mem[addr] & ~wmask) | (din & wmask);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout     <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= acc_ok && !rw;
            if (acc_ok && !rw)
                dout <= mem[addr];
        end
    end
endmodule

// File: tb/tb_ram_sync_clr.sv
// tb_ram_sync_clr: directed vector table plus hand-written clear/reset sequences
// for ram_sync_clr; the clear-controller sequences are built only with RAM_CLEAR_EN.
module tb_ram_sync_clr;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
    logic [3:0]        be;
    logic              clr;
    logic [DATA_W-1:0] dout;
    logic              rd_valid;
    logic              busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ram_sync_clr #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .en(en), .rw(rw), .addr(addr), .din(din),
        .be(be), .clr(clr), .dout(dout), .rd_valid(rd_valid), .busy(busy)
    );

    typedef struct {
        logic        en;
        logic        rw;
        logic [7:0]  addr;
        logic [31:0] din;
        logic [3:0]  be;
        logic [31:0] exp_dout;
        logic        exp_rv;
    } vec_t;

    vec_t tbl[16];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic write_word(input logic [7:0] a, input logic [31:0] d, input logic [3:0] b);
        en = 1'b1; rw = 1'b1; addr = a; din = d; be = b;
        step();
        en = 1'b0; rw = 1'b0;
    endtask

    task automatic read_chk(input logic [7:0] a, input logic [31:0] exp, input string name);
        en = 1'b1; rw = 1'b0; addr = a;
        step();
        en = 1'b0;
        check({name, " rd_valid"}, {31'b0, rd_valid}, 32'd1);
        check({name, " dout"}, dout, exp);
    endtask

    // Counts consecutive sampled cycles with busy=1, starting with the current one.
    task automatic count_busy(output int n, output int rv_seen);
        n = 0;
        rv_seen = 0;
        while (busy && n < 2000) begin
            n++;
            if (rd_valid) rv_seen++;
            step();
        end
    endtask

    logic [31:0] model [16];
    int          n;
    int          rv_seen;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; en = 1'b0; rw = 1'b0; addr = '0; din = '0; be = '0; clr = 1'b0;
        step();
        check("reset dout", dout, 32'h0);
        check("reset rd_valid", {31'b0, rd_valid}, 32'd0);
`ifdef RAM_CLEAR_EN
        check("reset busy", {31'b0, busy}, 32'd1);
        rst = 1'b0;
        count_busy(n, rv_seen);
        check("power-up clear length", n, 32'd256);
        read_chk(8'd0,   32'h0, "cleared addr 0");
        read_chk(8'd127, 32'h0, "cleared addr 127");
        read_chk(8'd255, 32'h0, "cleared addr 255");
`else
        check("reset busy", {31'b0, busy}, 32'd0);
        rst = 1'b0;
`endif

        tbl[0]  = '{1'b1, 1'b1, 8'h05, 32'hAABBCCDD, 4'hF, 32'h00000000, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 8'h05, 32'h11223344, 4'h5, 32'h00000000, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 8'h05, 32'h00000000, 4'h0, 32'hAA22CC44, 1'b1};
        tbl[3]  = '{1'b1, 1'b1, 8'h03, 32'hDEADBEEF, 4'hF, 32'hAA22CC44, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 8'h03, 32'h00000000, 4'h0, 32'hDEADBEEF, 1'b1};
        tbl[5]  = '{1'b0, 1'b0, 8'h05, 32'h00000000, 4'h0, 32'hDEADBEEF, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 8'h03, 32'h00000000, 4'h0, 32'hDEADBEEF, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 8'h03, 32'h00000000, 4'h0, 32'hDEADBEEF, 1'b1};
        tbl[8]  = '{1'b1, 1'b1, 8'h05, 32'hFFFFFFFF, 4'hA, 32'hDEADBEEF, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 8'h05, 32'h00000000, 4'hF, 32'hDEADBEEF, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 8'h05, 32'h00000000, 4'h0, 32'hFF22FF44, 1'b1};
        tbl[11] = '{1'b1, 1'b1, 8'hFF, 32'h0F0F0F0F, 4'hF, 32'hFF22FF44, 1'b0};
        tbl[12] = '{1'b1, 1'b1, 8'h00, 32'h55AA55AA, 4'hF, 32'hFF22FF44, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 8'hFF, 32'h00000000, 4'h0, 32'h0F0F0F0F, 1'b1};
        tbl[14] = '{1'b1, 1'b0, 8'h00, 32'h00000000, 4'h0, 32'h55AA55AA, 1'b1};
        tbl[15] = '{1'b1, 1'b0, 8'h05, 32'h00000000, 4'h0, 32'hFF22FF44, 1'b1};

        for (int i = 0; i < 16; i++) begin
            en = tbl[i].en; rw = tbl[i].rw; addr = tbl[i].addr;
            din = tbl[i].din; be = tbl[i].be;
            step();
            check($sformatf("vec%0d dout", i), dout, tbl[i].exp_dout);
            check($sformatf("vec%0d rd_valid", i), {31'b0, rd_valid}, {31'b0, tbl[i].exp_rv});
            check($sformatf("vec%0d busy", i), {31'b0, busy}, 32'd0);
        end
        en = 1'b0;

        for (int i = 0; i < 16; i++) begin
            model[i] = $urandom;
            write_word(8'h10 + 8'(i), model[i], 4'hF);
        end
        for (int i = 0; i < 16; i++)
            read_chk(8'h10 + 8'(i), model[i], $sformatf("rand addr %0h", 16 + i));

`ifdef RAM_CLEAR_EN
        for (int i = 0; i < 256; i++)
            write_word(8'(i), {8'hA5, 8'(i), ~8'(i), 8'h5A}, 4'hF);
        read_chk(8'd200, {8'hA5, 8'd200, ~8'd200, 8'h5A}, "filled addr 200");

        clr = 1'b1; en = 1'b1; rw = 1'b0; addr = 8'h10;
        step();
        clr = 1'b0;
        check("clr beats read rd_valid", {31'b0, rd_valid}, 32'd0);
        check("clr enters busy", {31'b0, busy}, 32'd1);
        n = 1;
        rv_seen = 0;
        repeat (99) begin
            step();
            if (busy) n++;
            if (rd_valid) rv_seen++;
        end
        clr = 1'b1;
        step();
        clr = 1'b0;
        begin
            int n2, rv2;
            count_busy(n2, rv2);
            check("clr restart busy length", n + n2, 32'd356);
            check("rd_valid during busy", rv_seen + rv2, 32'd0);
        end
        en = 1'b0;
        for (int i = 0; i < 256; i++)
            read_chk(8'(i), 32'h0, $sformatf("after clr addr %0d", i));

        write_word(8'd7, 32'h12345678, 4'hF);
        read_chk(8'd7, 32'h12345678, "pre-rst addr 7");
        clr = 1'b1;
        step();
        clr = 1'b0;
        repeat (49) step();
        check("busy at clear cycle 50", {31'b0, busy}, 32'd1);
        rst = 1'b1; clr = 1'b1; en = 1'b1; rw = 1'b0; addr = 8'd7;
        step();
        rst = 1'b0; clr = 1'b0; en = 1'b0;
        check("mid-clear rst dout", dout, 32'h0);
        check("mid-clear rst rd_valid", {31'b0, rd_valid}, 32'd0);
        count_busy(n, rv_seen);
        check("busy after mid-clear rst", n, 32'd256);
        read_chk(8'd7, 32'h0, "addr 7 after clear");
`else
        en = 1'b1; rw = 1'b0; addr = 8'd3; rst = 1'b1;
        step();
        rst = 1'b0; en = 1'b0;
        check("rst over read dout", dout, 32'h0);
        check("rst over read rd_valid", {31'b0, rd_valid}, 32'd0);
        check("rst busy", {31'b0, busy}, 32'd0);
        read_chk(8'd3, 32'hDEADBEEF, "addr 3 kept over rst");

        clr = 1'b1; en = 1'b1; rw = 1'b0; addr = 8'd5;
        step();
        clr = 1'b0; en = 1'b0;
        check("clr ignored rd_valid", {31'b0, rd_valid}, 32'd1);
        check("clr ignored dout", dout, 32'hFF22FF44);
        rv_seen = 0;
        repeat (5) begin
            step();
            if (busy) rv_seen++;
        end
        check("busy stays 0", rv_seen, 32'd0);
        read_chk(8'hFF, 32'h0F0F0F0F, "addr FF after clr");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ram_sync_clr.md
RAM_SYNC_CLR -- requirements
Module: ram_sync_clr

Interface
REQ-001 Parameter DATA_W, default 32, data word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 8, address width; depth DEPTH = 2**ADDR_W words.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 en  input  1  access request valid this cycle.
REQ-006 rw  input  1  1 = write, 0 = read; sampled only when en=1.
REQ-007 addr  input  ADDR_W  word address.
REQ-008 din  input  DATA_W  write data.
REQ-009 be  input  DATA_W/8  byte enables; bit k gates din[8k+7:8k].
REQ-010 clr  input  1  single-cycle request to zero the whole array.
REQ-011 dout  output  DATA_W  registered read data.
REQ-012 rd_valid  output  1  one-cycle pulse; dout is updated this cycle.
REQ-013 busy  output  1  clear sequence in progress; requests are ignored.

Function
REQ-014 Controller SHALL have two states: CLEAR and IDLE.
REQ-015 CLEAR SHALL write all-zero to word clr_ptr each cycle, clr_ptr counting from 0 to DEPTH-1, and SHALL go to IDLE on the cycle after word DEPTH-1 is written (DEPTH cycles total with busy=1).
REQ-016 busy SHALL be 1 in CLEAR and 0 in IDLE.
REQ-017 In CLEAR, en, rw, addr, din, be SHALL be ignored: no user write, no rd_valid.
REQ-018 clr=1 in IDLE SHALL enter CLEAR with clr_ptr=0 on the next edge; clr=1 in CLEAR SHALL restart clr_ptr at 0.
REQ-019 clr=1 together with en=1 in IDLE SHALL give priority to clr: the access is dropped.
REQ-020 Write: en=1, rw=1 in IDLE SHALL update only the bytes of mem[addr] whose be bit is 1, at that edge; be=0 gives no change.
REQ-021 Read: en=1, rw=0 in IDLE at edge N SHALL load mem[addr] into dout and set rd_valid=1 after edge N (latency 1 cycle).
REQ-022 rd_valid SHALL be 0 in every cycle not following an accepted read.
REQ-023 dout SHALL hold its last value when no read is accepted.
REQ-024 Read after write to the same address on consecutive cycles SHALL return the newly written data.
REQ-025 Address range is full; no out-of-range case exists; clr_ptr SHALL NOT wrap past DEPTH-1.

Reset
REQ-026 rst=1 SHALL set dout=0 and rd_valid=0, and SHALL force CLEAR with clr_ptr=0 (busy=1 on the following cycle).
REQ-027 rst asserted mid-CLEAR SHALL restart the sequence at word 0; rst SHALL take priority over clr and en.
REQ-028 rst SHALL NOT, by itself, alter memory contents; contents are zeroed only by the CLEAR sequence.

Configuration
REQ-029 Macro RAM_CLEAR_EN: when defined, CLEAR state, clr_ptr, clr input and busy behave as in REQ-014..REQ-019 and REQ-026..REQ-027.
REQ-030 Without RAM_CLEAR_EN: the controller SHALL be permanently IDLE, busy SHALL be tied 0, clr SHALL be ignored, rst SHALL reset only dout and rd_valid, and memory contents after power-up SHALL be undefined.

Verification
REQ-031 Defaults, RAM_CLEAR_EN defined, rst pulse -> busy=1 for exactly 256 cycles, then 0; reads of addrs 0, 127, 255 -> dout=0x00000000 with rd_valid one cycle after each request.
REQ-032 Write addr 0x10..0x1F with be=4'hF, din=$random-style values, then read all -> each dout matches the written value, latency 1.
REQ-033 Write 0xAABBCCDD with be=4'hF to addr 5, then 0x11223344 with be=4'b0101 -> read addr 5 = 0xAA22CC44.
REQ-034 Fill addrs 0..255 with nonzero data, pulse clr, at clear cycle 100 pulse clr again -> busy high for 100+256 cycles total; all reads then return 0; en during busy gives no rd_valid.
REQ-035 Pulse rst at clear cycle 50 -> busy stays high 256 more cycles; dout=0 and rd_valid=0 during the reset cycle.
REQ-036 Build without RAM_CLEAR_EN: rst then write/read addr 3 with 0xDEADBEEF -> busy constantly 0, clr ignored, read returns 0xDEADBEEF.
